apb_timer_slave: RTL and testbench
==================================

Name: apb_timer_slave

Overview:
- APB3 timer peripheral. Sits directly downstream of the AHB-to-APB bridge on the same HCLK domain and is qualified by PCLKEN.
- Provides four word-aligned registers: CTRL, LOAD, VALUE and STATUS.
- Contains a 32-bit down-counter with one-shot or auto-reload mode and a level interrupt.
- Inserts a parameterised number of wait states through PREADY and flags illegal accesses on PSLVERR.

Parameters:
- ADDRWIDTH, 16, APB address width. Only PADDR[3:2] decode a register; PADDR[ADDRWIDTH-1:4] must be zero for a mapped access.
- DATAWIDTH, 32, APB data width and counter width. Fixed at 32.
- WAIT_STATES, 1, number of PREADY-low access cycles, counted in PCLKEN-qualified cycles. Legal range 0..15.

Ports:
- HCLK  in  1  single clock for the APB interface and the counter.
- HRESET  in  1  asynchronous reset, active-high.
- PCLKEN  in  1  APB clock enable. APB handshake state advances only when it is 1.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable (access phase).
- PADDR  in  ADDRWIDTH  APB byte address.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATAWIDTH  write data.
- PRDATA  out  DATAWIDTH  read data, valid while PREADY=1.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response, valid while PREADY=1.
- TIMER_IRQ  out  1  interrupt = STATUS.IRQ & CTRL.IE.

Behaviour:
- Reset: all outputs 0. Registers reset to CTRL=0, LOAD=0, VALUE=0, STATUS=0. FSM resets to IDLE. The wait counter resets to 0.
- Register map (offset, access, fields):
  - 0x0 CTRL, RW: bit0 EN, bit1 IE, bit2 RELOAD. Other bits read 0.
  - 0x4 LOAD, RW. A write also copies PWDATA into VALUE in the same commit cycle.
  - 0x8 VALUE, RO. A write returns PSLVERR=1 and changes nothing.
  - 0xC STATUS, bit0 IRQ, W1C. Writing 0 has no effect. Other bits read 0.
  - Any address with PADDR[ADDRWIDTH-1:4]≠0, or PADDR[1:0]≠0: PSLVERR=1, PRDATA=0, no state change.
- FSM states: IDLE and ACCESS.
  - IDLE → ACCESS when PSEL & !PENABLE & PCLKEN. In that cycle, capture address, write flag and write data; load wcnt=WAIT_STATES.
  - ACCESS: PREADY = (wcnt==0). PRDATA and PSLVERR are combinational from the captured address and are driven only while PREADY=1; otherwise they are 0.
  - ACCESS: wcnt decrements on each PCLKEN cycle while it is nonzero.
  - ACCESS → IDLE when PREADY & PSEL & PENABLE & PCLKEN. The write commits in this cycle, and only if PSLVERR=0.
  - ACCESS → IDLE if PSEL drops (aborted transfer). No commit.
- Latency: WAIT_STATES=0 completes in the first access cycle. WAIT_STATES=N adds N PCLKEN-qualified low-PREADY cycles.
- A VALUE read returns the counter as it stands in the completing cycle.
- Counter (every HCLK cycle, independent of PCLKEN):
  - EN=1 & VALUE≠0: VALUE decrements by 1.
  - EN=1 & VALUE==0: set STATUS.IRQ. If RELOAD=1, VALUE←LOAD. Otherwise EN←0 and VALUE stays 0.
  - EN=0: VALUE holds.
- Simultaneous events:
  - IRQ set and W1C in the same cycle: set wins, IRQ=1.
  - LOAD write in the same cycle as a decrement or expiry: the written value wins in VALUE. IRQ is still set if expiry occurred.
  - CTRL write clearing EN in the same cycle as expiry: EN=0 and IRQ=1.
- Wrap: VALUE never underflows past 0.
- Reset mid-transfer: immediate return to IDLE with PREADY=0. A pending write is discarded.

Test Plan:
- Reset then read CTRL, LOAD, VALUE and STATUS (WAIT_STATES=1, PCLKEN=1) → each completes with PRDATA=0 and PSLVERR=0, with exactly 1 PREADY-low access cycle.
- Write LOAD=5, then CTRL=0x3 (EN, IE, one-shot) → VALUE counts 5..0. The cycle after VALUE reaches 0: IRQ=1, TIMER_IRQ=1, EN=0, VALUE holds 0.
- Then write STATUS=0x1 → TIMER_IRQ=0. Write STATUS=0x0 after a new expiry → IRQ stays 1.
- LOAD=2, CTRL=0x5 (EN, RELOAD) → VALUE sequence 2,1,0,2,1,0. IRQ set at each 0, including the same-cycle W1C case, where IRQ stays 1.
- Write to 0x8, and read/write 0x10 and 0x2 → PSLVERR=1 on PREADY. Registers are unchanged and PRDATA=0.
- WAIT_STATES=3, with PCLKEN toggling 1,0,1,0 → PREADY rises only after 3 PCLKEN-high access cycles.
- Assert HRESET during the wait phase of a LOAD write of 0xAA → PREADY=0 immediately; after release LOAD=0.

Source files
------------

// File: rtl/apb_timer_if.sv
// APB3 bus bundle between the AHB-to-APB bridge and the timer slave.
// PCLKEN travels with the bus because it qualifies every handshake step.
interface apb_timer_if #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
);
    logic                 PCLKEN;
    logic                 PSEL;
    logic                 PENABLE;
    logic [ADDRWIDTH-1:0] PADDR;
    logic                 PWRITE;
    logic [DATAWIDTH-1:0] PWDATA;
    logic [DATAWIDTH-1:0] PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    modport master (
        output PCLKEN, PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PCLKEN, PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_timer_slave.sv
// APB3 timer peripheral: CTRL/LOAD/VALUE/STATUS registers, a 32-bit
// down-counter (one-shot or auto-reload) with a level interrupt, and a
// configurable number of PCLKEN-qualified wait states on PREADY.
module apb_timer_slave #(
    parameter int ADDRWIDTH   = 16,
    parameter int DATAWIDTH   = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic          HCLK,
    input  logic          HRESET,
    apb_timer_if.slave    apb,
    output logic          TIMER_IRQ
);
    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_LOAD   = 2'd1;
    localparam logic [1:0] SEL_VALUE  = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    // Bus-side state
    state_t               state_q, state_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic                 write_q, write_d;
    logic [DATAWIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]           wcnt_q, wcnt_d;

    // Timer registers
    logic                 en_q, en_d;
    logic                 ie_q, ie_d;
    logic                 reload_q, reload_d;
    logic                 irq_q, irq_d;
    logic [DATAWIDTH-1:0] load_q, load_d;
    logic [DATAWIDTH-1:0] value_q, value_d;

    logic                 mapped;
    logic [1:0]           reg_sel;
    logic                 access_err;
    logic                 ready;
    logic                 commit;
    logic                 expire;
    logic [DATAWIDTH-1:0] rdata;

    // Decode of the captured address; decisions are made on the copy taken
    // in the setup phase, not on the live bus.
    assign mapped     = (addr_q[ADDRWIDTH-1:4] == '0) && (addr_q[1:0] == 2'b00);
    assign reg_sel    = addr_q[3:2];
    assign access_err = !mapped || (write_q && (reg_sel == SEL_VALUE));
    assign ready      = (state_q == ST_ACCESS) && (wcnt_q == 4'd0);
    assign commit     = ready && apb.PSEL && apb.PENABLE && apb.PCLKEN
                        && write_q && !access_err;
    assign expire     = en_q && (value_q == '0);

    // Register read multiplexer
    always_comb begin
        rdata = '0;
        case (reg_sel)
            SEL_CTRL:   rdata = {{(DATAWIDTH-3){1'b0}}, reload_q, ie_q, en_q};
            SEL_LOAD:   rdata = load_q;
            SEL_VALUE:  rdata = value_q;
            SEL_STATUS: rdata = {{(DATAWIDTH-1){1'b0}}, irq_q};
            default:    rdata = '0;
        endcase
    end

    // Response outputs are only non-zero in the completing (ready) cycle
    assign apb.PREADY  = ready;
    assign apb.PSLVERR = ready && access_err;
    assign apb.PRDATA  = (ready && !access_err) ? rdata : '0;
    assign TIMER_IRQ   = irq_q && ie_q;

    // APB handshake next-state: setup capture, wait countdown, completion/abort
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (apb.PSEL && !apb.PENABLE && apb.PCLKEN) begin
                    state_d = ST_ACCESS;
                    addr_d  = apb.PADDR;
                    write_d = apb.PWRITE;
                    wdata_d = apb.PWDATA;
                    wcnt_d  = WAIT_INIT;
                end
            end
            ST_ACCESS: begin
                if (!apb.PSEL) begin
                    // Master abandoned the transfer: nothing commits
                    state_d = ST_IDLE;
                end else if (apb.PCLKEN) begin
                    if (wcnt_q != 4'd0) begin
                        wcnt_d = wcnt_q - 4'd1;
                    end else if (apb.PENABLE) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter and register next-state; bus writes are applied after the
    // counter so a written value overrides the count, while an expiry in
    // the same cycle still raises IRQ.
    always_comb begin
        en_d     = en_q;
        ie_d     = ie_q;
        reload_d = reload_q;
        irq_d    = irq_q;
        load_d   = load_q;
        value_d  = value_q;

        if (en_q) begin
            if (value_q != '0) begin
                value_d = value_q - 1'b1;
            end else begin
                irq_d = 1'b1;
                if (reload_q) begin
                    value_d = load_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        if (commit) begin
            case (reg_sel)
                SEL_CTRL: begin
                    en_d     = wdata_q[0];
                    ie_d     = wdata_q[1];
                    reload_d = wdata_q[2];
                end
                SEL_LOAD: begin
                    load_d  = wdata_q;
                    value_d = wdata_q;
                end
                SEL_STATUS: begin
                    // Clear loses to a simultaneous set
                    if (wdata_q[0] && !expire) begin
                        irq_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus-side state register
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Timer register file
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            reload_q <= 1'b0;
            irq_q    <= 1'b0;
            load_q   <= '0;
            value_q  <= '0;
        end else begin
            en_q     <= en_d;
            ie_q     <= ie_d;
            reload_q <= reload_d;
            irq_q    <= irq_d;
            load_q   <= load_d;
            value_q  <= value_d;
        end
    end
endmodule

// File: tb/tb_apb_timer_slave.sv
// Bench for apb_timer_slave: directed APB transfers, expected responses
// queued per transfer and checked by a monitor on completion.
module tb_apb_timer_slave;
    logic clk = 1'b0;
    logic rst;
    logic irq0, irq1;

    always #5 clk = ~clk;

    apb_timer_if #(.ADDRWIDTH(16), .DATAWIDTH(32)) bus0 ();
    apb_timer_if #(.ADDRWIDTH(16), .DATAWIDTH(32)) bus1 ();

    apb_timer_slave #(.ADDRWIDTH(16), .DATAWIDTH(32), .WAIT_STATES(1)) dut0 (
        .HCLK(clk), .HRESET(rst), .apb(bus0), .TIMER_IRQ(irq0)
    );
    apb_timer_slave #(.ADDRWIDTH(16), .DATAWIDTH(32), .WAIT_STATES(3)) dut1 (
        .HCLK(clk), .HRESET(rst), .apb(bus1), .TIMER_IRQ(irq1)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t mon0_e, mon1_e;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pop one expectation per completed transfer on dut0
    always @(negedge clk) begin
        if (bus0.PSEL && bus0.PENABLE && bus0.PREADY && bus0.PCLKEN) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0_unexpected_response: got a completion expected none");
            end else begin
                mon0_e = q0.pop_front();
                check("dut0_pslverr", {31'b0, bus0.PSLVERR}, {31'b0, mon0_e.err});
                if (mon0_e.chk_data) check("dut0_prdata", bus0.PRDATA, mon0_e.rdata);
                $display("dut0 %s addr=0x%04h prdata=0x%08h pslverr=%0b",
                         bus0.PWRITE ? "WR" : "RD", bus0.PADDR, bus0.PRDATA, bus0.PSLVERR);
            end
        end
    end

    // Monitor: same for dut1
    always @(negedge clk) begin
        if (bus1.PSEL && bus1.PENABLE && bus1.PREADY && bus1.PCLKEN) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1_unexpected_response: got a completion expected none");
            end else begin
                mon1_e = q1.pop_front();
                check("dut1_pslverr", {31'b0, bus1.PSLVERR}, {31'b0, mon1_e.err});
                if (mon1_e.chk_data) check("dut1_prdata", bus1.PRDATA, mon1_e.rdata);
                $display("dut1 %s addr=0x%04h prdata=0x%08h pslverr=%0b",
                         bus1.PWRITE ? "WR" : "RD", bus1.PADDR, bus1.PRDATA, bus1.PSLVERR);
            end
        end
    end

    // One transfer on dut0 (PCLKEN held high). Called just after a rising
    // edge; completes two cycles later and returns one cycle after that.
    task automatic apb0(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int  low;
        logic done;
        q0.push_back('{exp_rdata, exp_err, (!wr || exp_err)});
        bus0.PSEL = 1'b1; bus0.PENABLE = 1'b0;
        bus0.PADDR = addr; bus0.PWRITE = wr; bus0.PWDATA = wdata;
        @(posedge clk); #1;
        bus0.PENABLE = 1'b1;
        low = 0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus0.PREADY && bus0.PCLKEN) done = 1'b1;
            else if (bus0.PCLKEN) low++;
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL dut0_timeout: got no PREADY expected completion within 40 cycles");
        end
        check("dut0_wait_cycles", 32'(low), 32'd1);
        bus0.PSEL = 1'b0; bus0.PENABLE = 1'b0; bus0.PWRITE = 1'b0;
    endtask

    // One transfer on dut1 with PCLKEN toggling every cycle from the setup cycle
    task automatic apb1(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int  low, cyc;
        logic done;
        q1.push_back('{exp_rdata, exp_err, (!wr || exp_err)});
        bus1.PCLKEN = 1'b1;
        bus1.PSEL = 1'b1; bus1.PENABLE = 1'b0;
        bus1.PADDR = addr; bus1.PWRITE = wr; bus1.PWDATA = wdata;
        @(posedge clk); #1;
        bus1.PENABLE = 1'b1;
        bus1.PCLKEN = 1'b0;
        low = 0; cyc = 0; done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            cyc++;
            if (bus1.PREADY && bus1.PCLKEN) done = 1'b1;
            else if (bus1.PCLKEN && !bus1.PREADY) low++;
            @(posedge clk); #1;
            bus1.PCLKEN = ~bus1.PCLKEN;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL dut1_timeout: got no PREADY expected completion within 60 cycles");
        end
        check("dut1_wait_cycles", 32'(low), 32'd3);
        check("dut1_access_cycles", 32'(cyc), 32'd8);
        bus1.PSEL = 1'b0; bus1.PENABLE = 1'b0; bus1.PWRITE = 1'b0; bus1.PCLKEN = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus0.PCLKEN = 1'b1; bus0.PSEL = 1'b0; bus0.PENABLE = 1'b0;
        bus0.PADDR = '0; bus0.PWRITE = 1'b0; bus0.PWDATA = '0;
        bus1.PCLKEN = 1'b1; bus1.PSEL = 1'b0; bus1.PENABLE = 1'b0;
        bus1.PADDR = '0; bus1.PWRITE = 1'b0; bus1.PWDATA = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pready", {31'b0, bus0.PREADY}, 32'd0);
        check("reset_pslverr", {31'b0, bus0.PSLVERR}, 32'd0);
        check("reset_prdata", bus0.PRDATA, 32'd0);
        check("reset_irq", {31'b0, irq0}, 32'd0);
        rst = 1'b0;

        // Reset values through the bus
        apb0(1'b0, 16'h0, 32'h0, 32'h0, 1'b0);
        apb0(1'b0, 16'h4, 32'h0, 32'h0, 1'b0);
        apb0(1'b0, 16'h8, 32'h0, 32'h0, 1'b0);
        apb0(1'b0, 16'hC, 32'h0, 32'h0, 1'b0);

        // One-shot: VALUE(k) = 5-k after the CTRL commit, IRQ from k=6
        apb0(1'b1, 16'h4, 32'd5, 32'h0, 1'b0);
        apb0(1'b1, 16'h0, 32'h3, 32'h0, 1'b0);
        check("oneshot_irq_before_expiry", {31'b0, irq0}, 32'd0);
        apb0(1'b0, 16'h8, 32'h0, 32'd3, 1'b0);   // completes k=2
        apb0(1'b0, 16'h8, 32'h0, 32'd0, 1'b0);   // completes k=5
        apb0(1'b0, 16'hC, 32'h0, 32'd1, 1'b0);   // IRQ set at k=6
        apb0(1'b0, 16'h0, 32'h0, 32'h2, 1'b0);   // EN cleared, IE kept
        check("oneshot_timer_irq", {31'b0, irq0}, 32'd1);
        apb0(1'b0, 16'h8, 32'h0, 32'd0, 1'b0);   // holds at 0

        // W1C clears, then a zero write after a fresh expiry leaves IRQ set
        apb0(1'b1, 16'hC, 32'h1, 32'h0, 1'b0);
        check("w1c_timer_irq", {31'b0, irq0}, 32'd0);
        apb0(1'b0, 16'hC, 32'h0, 32'd0, 1'b0);
        apb0(1'b1, 16'h4, 32'd1, 32'h0, 1'b0);
        apb0(1'b1, 16'h0, 32'h3, 32'h0, 1'b0);
        apb0(1'b1, 16'hC, 32'h0, 32'h0, 1'b0);
        apb0(1'b0, 16'hC, 32'h0, 32'd1, 1'b0);
        check("w0_timer_irq", {31'b0, irq0}, 32'd1);
        apb0(1'b1, 16'hC, 32'h1, 32'h0, 1'b0);
        apb0(1'b0, 16'hC, 32'h0, 32'd0, 1'b0);

        // Auto-reload: VALUE(k) = 2 - (k mod 3) after the CTRL commit
        apb0(1'b1, 16'h4, 32'd2, 32'h0, 1'b0);
        apb0(1'b1, 16'h0, 32'h5, 32'h0, 1'b0);
        apb0(1'b0, 16'h8, 32'h0, 32'd0, 1'b0);   // completes k=2
        idle(1);
        apb0(1'b0, 16'h8, 32'h0, 32'd2, 1'b0);   // completes k=6
        apb0(1'b0, 16'hC, 32'h0, 32'd1, 1'b0);   // completes k=9
        check("reload_irq_masked", {31'b0, irq0}, 32'd0);
        idle(2);
        apb0(1'b1, 16'hC, 32'h1, 32'h0, 1'b0);   // W1C at k=14, same edge as expiry
        apb0(1'b0, 16'hC, 32'h0, 32'd1, 1'b0);   // completes k=17
        idle(1);
        apb0(1'b1, 16'h0, 32'h0, 32'h0, 1'b0);   // stop at k=21, VALUE 2 -> 1
        apb0(1'b0, 16'h8, 32'h0, 32'd1, 1'b0);
        apb0(1'b1, 16'h4, 32'd7, 32'h0, 1'b0);

        // Illegal accesses: error response, no state change
        apb0(1'b1, 16'h8,  32'h55, 32'h0, 1'b1);
        apb0(1'b0, 16'h10, 32'h0,  32'h0, 1'b1);
        apb0(1'b1, 16'h10, 32'h1,  32'h0, 1'b1);
        apb0(1'b0, 16'h2,  32'h0,  32'h0, 1'b1);
        apb0(1'b1, 16'h2,  32'h7,  32'h0, 1'b1);
        apb0(1'b0, 16'h0, 32'h0, 32'h0, 1'b0);
        apb0(1'b0, 16'h4, 32'h0, 32'd7, 1'b0);
        apb0(1'b0, 16'h8, 32'h0, 32'd7, 1'b0);
        apb0(1'b0, 16'hC, 32'h0, 32'd1, 1'b0);

        // Three wait states with PCLKEN toggling
        apb1(1'b1, 16'h4, 32'h1234, 32'h0, 1'b0);
        apb1(1'b0, 16'h4, 32'h0, 32'h1234, 1'b0);
        apb1(1'b0, 16'h8, 32'h0, 32'h1234, 1'b0);

        // Reset during the wait phase of a LOAD write
        bus0.PSEL = 1'b1; bus0.PENABLE = 1'b0;
        bus0.PADDR = 16'h4; bus0.PWRITE = 1'b1; bus0.PWDATA = 32'hAA;
        @(posedge clk); #1;
        bus0.PENABLE = 1'b1;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("midreset_pready", {31'b0, bus0.PREADY}, 32'd0);
        @(posedge clk); #1;
        check("midreset_pready_held", {31'b0, bus0.PREADY}, 32'd0);
        bus0.PSEL = 1'b0; bus0.PENABLE = 1'b0; bus0.PWRITE = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("dut0 reset during LOAD write of 0xAA");
        apb0(1'b0, 16'h4, 32'h0, 32'h0, 1'b0);
        apb0(1'b0, 16'hC, 32'h0, 32'h0, 1'b0);

        idle(2);
        check("dut0_queue_drained", 32'(q0.size()), 32'd0);
        check("dut1_queue_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
